// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the built-in demo program and
// the program-memory state type.
package cpu_pkg;

  localparam logic [7:0] NOP = 8'hFF;

  localparam int unsigned PROG_LEN = 10;

  localparam logic [7:0] DEFAULT_PROG [PROG_LEN] = '{
    8'hB2, 8'hB0, 8'h88, 8'h08, 8'h50, 8'hFF, 8'hB1, 8'hA0, 8'h87, 8'hC0
  };

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD
  } mem_state_t;

  // Demo-program word for an address; NOP beyond the end of the program.
  function automatic logic [7:0] default_word(input int unsigned addr);
    logic [7:0] w;
    w = NOP;
    for (int unsigned i = 0; i < PROG_LEN; i++) begin
      if (addr == i) w = DEFAULT_PROG[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/prog_mem_ram.sv
// DATA_W x DEPTH storage with one synchronous write port and one registered
// read port; the read register clears on reset.
module prog_mem_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/prog_mem.sv
// Writable program memory: self-initialises with the demo program after
// reset, serves 1-cycle registered fetches and accepts streamed loads.
module prog_mem
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done
);

  localparam int unsigned     RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2^ADDR_W stays representable in compares.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_X  = (ADDR_W + 1)'(DEPTH - 1);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, ptr_q;
  logic              done_q, valid_q, oor_q;
  logic              cnt_last, ptr_last, fetch_in_range, base_in_range;
  logic              fetch_acc, ram_we, ram_re;
  logic [RAM_AW-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, init_word;

  assign cnt_last       = ({1'b0, cnt_q} == LAST_X);
  assign ptr_last       = ({1'b0, ptr_q} == LAST_X);
  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_X);
  assign base_in_range  = ({1'b0, load_base} < DEPTH_X);
  assign init_word      = (32'(cnt_q) < PROG_LEN) ? DATA_W'(default_word(32'(cnt_q))) : '1;

  always_comb begin
    state_d   = state_q;
    fetch_acc = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    unique case (state_q)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q[RAM_AW-1:0];
        ram_wdata = init_word;
        if (cnt_last) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        fetch_acc = fetch_req;
        if (load_start && base_in_range) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_valid) begin
          ram_we    = 1'b1;
          ram_waddr = ptr_q[RAM_AW-1:0];
          ram_wdata = load_data;
          if (load_last || ptr_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Out-of-range fetches skip the array and are answered with NOP from oor_q.
  assign ram_re = fetch_acc && fetch_in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= fetch_acc;
      done_q  <= 1'b0;
      if (fetch_acc) oor_q <= !fetch_in_range;
      unique case (state_q)
        ST_INIT: cnt_q <= cnt_q + 1'b1;
        ST_IDLE: begin
          if (load_start) begin
            if (base_in_range) ptr_q <= load_base;
            else               done_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            if (load_last || ptr_last) done_q <= 1'b1;
            else                       ptr_q  <= ptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  prog_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (fetch_addr[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  assign busy        = (state_q != ST_IDLE);
  assign fetch_ready = (state_q == ST_IDLE);
  assign load_ready  = (state_q == ST_LOAD);
  assign load_done   = done_q;
  assign fetch_valid = valid_q;
  assign fetch_err   = valid_q && oor_q;
  assign fetch_data  = oor_q ? '1 : ram_rdata;

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: a 256-word instance and a 16-word instance checked
// against an array model of the memory contents.
module tb_prog_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 256-word instance
  logic       rst_n, busy, fetch_req, fetch_ready, fetch_valid, fetch_err;
  logic       load_start, load_valid, load_last, load_ready, load_done;
  logic [7:0] fetch_addr, fetch_data, load_base, load_data;
  // 16-word instance
  logic       rst_n_s, busy_s, fetch_req_s, fetch_ready_s, fetch_valid_s, fetch_err_s;
  logic       load_start_s, load_valid_s, load_last_s, load_ready_s, load_done_s;
  logic [7:0] fetch_addr_s, fetch_data_s, load_base_s, load_data_s;

  int unsigned n_cmp, n_fail;
  logic [7:0]  prog [10];
  logic [7:0]  model [256];

  prog_mem dut (
    .clk(clk), .rst_n(rst_n), .busy(busy),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_done(load_done)
  );

  prog_mem #(.DEPTH(16)) dut_s (
    .clk(clk), .rst_n(rst_n_s), .busy(busy_s),
    .fetch_req(fetch_req_s), .fetch_addr(fetch_addr_s), .fetch_ready(fetch_ready_s),
    .fetch_valid(fetch_valid_s), .fetch_data(fetch_data_s), .fetch_err(fetch_err_s),
    .load_start(load_start_s), .load_base(load_base_s), .load_valid(load_valid_s),
    .load_data(load_data_s), .load_last(load_last_s), .load_ready(load_ready_s),
    .load_done(load_done_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model;
    for (int i = 0; i < 256; i++) model[i] = (i < 10) ? prog[i] : 8'hFF;
  endtask

  task automatic fetch(input logic [7:0] a, output logic v, output logic [7:0] d, output logic e);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
    v = fetch_valid; d = fetch_data; e = fetch_err;
  endtask

  task automatic fetch_s(input logic [7:0] a, output logic v, output logic [7:0] d, output logic e);
    fetch_req_s = 1'b1; fetch_addr_s = a;
    tick();
    fetch_req_s = 1'b0;
    v = fetch_valid_s; d = fetch_data_s; e = fetch_err_s;
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0; rst_n_s = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({busy, fetch_ready, fetch_valid, fetch_err, load_ready, load_done} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 100000",
               {busy, fetch_ready, fetch_valid, fetch_err, load_ready, load_done});
    end
    n_cmp++;
    if (fetch_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00", fetch_data);
    end
    rst_n = 1'b1; rst_n_s = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != 256) begin
      n_fail++; $display("FAIL init_busy_cycles: got %0d expected 256", n);
    end
    n_cmp++;
    if (fetch_ready !== 1'b1 || fetch_ready_s !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_init: got %b/%b expected 1/1", fetch_ready, fetch_ready_s);
    end
  endtask

  task automatic test_defaults;
    logic v, e; logic [7:0] d;
    logic [7:0] addrs [3];
    addrs[0] = 8'd0; addrs[1] = 8'd10; addrs[2] = 8'd9;
    for (int i = 0; i < 3; i++) begin
      fetch(addrs[i], v, d, e);
      n_cmp++;
      if ({v, e, d} !== {1'b1, 1'b0, model[addrs[i]]}) begin
        n_fail++;
        $display("FAIL default_fetch[%0d]: got v=%b e=%b d=%h expected v=1 e=0 d=%h",
                 addrs[i], v, e, d, model[addrs[i]]);
      end
    end
    tick();
    n_cmp++;
    if (fetch_valid !== 1'b0 || fetch_data !== 8'hC0) begin
      n_fail++; $display("FAIL fetch_hold: got v=%b d=%h expected v=0 d=C0", fetch_valid, fetch_data);
    end
  endtask

  task automatic test_back_to_back;
    fetch_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      fetch_addr = 8'(k);
      tick();
      n_cmp++;
      if (fetch_valid !== 1'b1 || fetch_data !== model[k]) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got v=%b d=%h expected v=1 d=%h", k, fetch_valid, fetch_data, model[k]);
      end
    end
    fetch_req = 1'b0;
    tick();
    n_cmp++;
    if (fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got v=%b expected 0", fetch_valid);
    end
  endtask

  task automatic test_load_last;
    logic v, e; logic [7:0] d;
    logic [7:0] beats [3];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    load_start = 1'b1; load_base = 8'h20;
    tick();
    load_start = 1'b0;
    n_cmp++;
    if ({load_ready, busy, fetch_ready} !== 3'b110) begin
      n_fail++; $display("FAIL load_enter: got %b expected 110", {load_ready, busy, fetch_ready});
    end
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1; load_data = beats[k]; load_last = (k == 2);
      fetch_req = (k == 0); fetch_addr = 8'h00;
      tick();
      fetch_req = 1'b0;
      model[8'h20 + k] = beats[k];
      n_cmp++;
      if (load_done !== (k == 2) || fetch_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL load_beat[%0d]: got done=%b fv=%b expected done=%b fv=0", k, load_done, fetch_valid, k == 2);
      end
    end
    load_valid = 1'b0; load_last = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || load_ready !== 1'b0) begin
      n_fail++; $display("FAIL load_exit: got busy=%b lr=%b expected 0 0", busy, load_ready);
    end
    tick();
    n_cmp++;
    if (load_done !== 1'b0 || fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_done_pulse: got done=%b fv=%b expected 0 0", load_done, fetch_valid);
    end
    for (int a = 8'h20; a <= 8'h23; a++) begin
      fetch(8'(a), v, d, e);
      n_cmp++;
      if (v !== 1'b1 || d !== model[a]) begin
        n_fail++; $display("FAIL load_readback[%h]: got v=%b d=%h expected v=1 d=%h", a, v, d, model[a]);
      end
    end
  endtask

  task automatic test_small;
    logic v, e; logic [7:0] d;
    logic [7:0] sm [16];
    logic [7:0] beats [3];
    for (int i = 0; i < 16; i++) sm[i] = (i < 10) ? prog[i] : 8'hFF;
    beats[0] = 8'hAA; beats[1] = 8'hBB; beats[2] = 8'hCC;
    fetch_s(8'h14, v, d, e);
    n_cmp++;
    if ({v, e, d} !== {1'b1, 1'b1, 8'hFF}) begin
      n_fail++; $display("FAIL small_oor: got v=%b e=%b d=%h expected v=1 e=1 d=ff", v, e, d);
    end
    fetch_s(8'h0F, v, d, e);
    n_cmp++;
    if ({v, e, d} !== {1'b1, 1'b0, sm[15]}) begin
      n_fail++; $display("FAIL small_top: got v=%b e=%b d=%h expected v=1 e=0 d=%h", v, e, d, sm[15]);
    end
    load_start_s = 1'b1; load_base_s = 8'd14;
    tick();
    load_start_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load_valid_s = 1'b1; load_data_s = beats[k]; load_last_s = 1'b0;
      tick();
      if (k < 2) sm[14 + k] = beats[k];
      n_cmp++;
      if (load_done_s !== (k == 1) || busy_s !== (k == 0)) begin
        n_fail++;
        $display("FAIL small_end_beat[%0d]: got done=%b busy=%b expected done=%b busy=%b",
                 k, load_done_s, busy_s, k == 1, k == 0);
      end
    end
    load_valid_s = 1'b0;
    for (int a = 13; a < 16; a++) begin
      fetch_s(8'(a), v, d, e);
      n_cmp++;
      if (v !== 1'b1 || e !== 1'b0 || d !== sm[a]) begin
        n_fail++; $display("FAIL small_readback[%0d]: got v=%b e=%b d=%h expected d=%h", a, v, e, d, sm[a]);
      end
    end
    load_start_s = 1'b1; load_base_s = 8'd16;
    tick();
    load_start_s = 1'b0;
    n_cmp++;
    if ({load_done_s, load_ready_s, fetch_ready_s} !== 3'b101) begin
      n_fail++; $display("FAIL small_bad_base: got %b expected 101", {load_done_s, load_ready_s, fetch_ready_s});
    end
    tick();
    n_cmp++;
    if (load_done_s !== 1'b0) begin
      n_fail++; $display("FAIL small_bad_base_pulse: got %b expected 0", load_done_s);
    end
  endtask

  task automatic test_simultaneous;
    logic v, e; logic [7:0] d;
    fetch_req = 1'b1; fetch_addr = 8'h00; load_start = 1'b1; load_base = 8'h00;
    tick();
    fetch_req = 1'b0; load_start = 1'b0;
    n_cmp++;
    if ({fetch_valid, load_ready} !== 2'b11 || fetch_data !== model[0]) begin
      n_fail++;
      $display("FAIL simul_fetch: got v=%b lr=%b d=%h expected v=1 lr=1 d=%h", fetch_valid, load_ready, fetch_data, model[0]);
    end
    load_valid = 1'b1; load_data = 8'h5A; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    model[0] = 8'h5A;
    n_cmp++;
    if (load_done !== 1'b1) begin
      n_fail++; $display("FAIL simul_done: got %b expected 1", load_done);
    end
    fetch(8'h00, v, d, e);
    n_cmp++;
    if (v !== 1'b1 || d !== model[0]) begin
      n_fail++; $display("FAIL simul_readback: got v=%b d=%h expected v=1 d=%h", v, d, model[0]);
    end
  endtask

  task automatic test_random;
    int base, len, p, sent, guard;
    bit ended, last;
    logic [7:0] dv, a;
    for (int r = 0; r < 8; r++) begin
      base = (r % 3 == 2) ? $urandom_range(248, 255) : $urandom_range(0, 255);
      len  = $urandom_range(1, 8);
      load_start = 1'b1; load_base = 8'(base);
      tick();
      load_start = 1'b0;
      p = base; sent = 0; ended = 0; guard = 0;
      while (!ended && guard < 64) begin
        guard++;
        if ($urandom_range(0, 2) == 0) begin
          load_valid = 1'b0; load_last = 1'b0; load_data = 8'($urandom);
          tick();
          n_cmp++;
          if (load_done !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++; $display("FAIL rnd_gap[%0d]: got done=%b lr=%b expected 0 1", r, load_done, load_ready);
          end
        end else begin
          dv = 8'($urandom);
          last = (sent == len - 1);
          load_valid = 1'b1; load_data = dv; load_last = last;
          tick();
          model[p] = dv;
          sent++;
          n_cmp++;
          if (load_done !== (last || p == 255)) begin
            n_fail++; $display("FAIL rnd_done[%0d]: got %b expected %b at addr %0d", r, load_done, last || p == 255, p);
          end
          if (last || p == 255) ended = 1;
          else p++;
        end
      end
      load_valid = 1'b0; load_last = 1'b0;
      if (!ended) begin
        n_cmp++; n_fail++;
        $display("FAIL rnd_load_timeout[%0d]: got no end expected end", r);
      end
      fetch_req = 1'b1;
      for (int k = 0; k < 12; k++) begin
        a = ($urandom_range(0, 1) == 1) ? 8'(base + $urandom_range(0, 8)) : 8'($urandom);
        fetch_addr = a;
        tick();
        n_cmp++;
        if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || fetch_data !== model[a]) begin
          n_fail++;
          $display("FAIL rnd_fetch[%h]: got v=%b e=%b d=%h expected v=1 e=0 d=%h", a, fetch_valid, fetch_err, fetch_data, model[a]);
        end
      end
      fetch_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid_load;
    logic v, e; logic [7:0] d;
    bit done_seen;
    int n;
    load_start = 1'b1; load_base = 8'h20;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h77; load_last = 1'b0;
    tick();
    load_valid = 1'b0;
    done_seen = (load_done === 1'b1);
    rst_n = 1'b0;
    repeat (3) begin
      tick();
      if (load_done !== 1'b0) done_seen = 1;
    end
    rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      if (load_done !== 1'b0) done_seen = 1;
      n++;
      tick();
    end
    if (load_done !== 1'b0) done_seen = 1;
    reset_model();
    n_cmp++;
    if (n != 256) begin
      n_fail++; $display("FAIL midload_init_cycles: got %0d expected 256", n);
    end
    n_cmp++;
    if (done_seen) begin
      n_fail++; $display("FAIL midload_done: got load_done pulse expected none");
    end
    fetch(8'h20, v, d, e);
    n_cmp++;
    if (v !== 1'b1 || d !== model[8'h20]) begin
      n_fail++; $display("FAIL midload_readback: got v=%b d=%h expected v=1 d=%h", v, d, model[8'h20]);
    end
    fetch(8'h00, v, d, e);
    n_cmp++;
    if (v !== 1'b1 || d !== model[0]) begin
      n_fail++; $display("FAIL midload_reinit0: got v=%b d=%h expected v=1 d=%h", v, d, model[0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    prog[0] = 8'hB2; prog[1] = 8'hB0; prog[2] = 8'h88; prog[3] = 8'h08; prog[4] = 8'h50;
    prog[5] = 8'hFF; prog[6] = 8'hB1; prog[7] = 8'hA0; prog[8] = 8'h87; prog[9] = 8'hC0;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0; load_base = '0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    rst_n_s = 1'b0; fetch_req_s = 1'b0; fetch_addr_s = '0; load_start_s = 1'b0; load_base_s = '0;
    load_valid_s = 1'b0; load_data_s = '0; load_last_s = 1'b0;
    reset_model();
    test_reset();
    test_defaults();
    test_back_to_back();
    test_load_last();
    test_small();
    test_simultaneous();
    test_random();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
